// File: rtl/fetch_sequencer.sv
// Program-counter and instruction-memory sequencer for the single-cycle RV32 core.
// Shares the instruction memory between the fetch path (RUN) and an external program loader.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [31:0] fetch_count,
  output logic        trap,
  output logic [31:0] trap_pc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    TRAP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic        r_trap;
  logic [31:0] r_trap_pc;

  logic w_run;
  logic w_ld_aligned;
  logic w_fetch;

  assign w_run        = (r_state == RUN);
  assign w_ld_aligned = (ld_addr[1:0] == 2'b00);
  assign w_fetch      = w_run && !stall;

  // Reset gates the write strobe directly so an in-flight loader write is dropped at once.
  assign ld_ready    = !reset && !w_run && w_ld_aligned;
  assign imem_we     = !reset && !w_run && w_ld_aligned && ld_valid;
  assign imem_addr   = w_run ? r_pc : ld_addr;
  assign imem_wdata  = w_run ? 32'h0000_0000 : ld_data;
  assign fetch_valid = w_fetch;

  assign pc          = r_pc;
  assign fetch_count = r_fetch_count;
  assign trap        = r_trap;
  assign trap_pc     = r_trap_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_VECTOR;
      r_fetch_count <= 32'h0000_0000;
      r_trap        <= 1'b0;
      r_trap_pc     <= 32'h0000_0000;
    end else begin
      case (r_state)
        RUN: begin
          if (w_fetch)
            r_fetch_count <= r_fetch_count + 32'd1;
          // Priority: halt > start > redirect > stall > increment.
          if (halt) begin
            r_state <= HALTED;
          end else if (start) begin
            r_pc          <= RESET_VECTOR;
            r_fetch_count <= 32'h0000_0000;
            r_trap        <= 1'b0;
          end else if (redirect_valid) begin
            if (redirect_target[1:0] == 2'b00) begin
              r_pc <= redirect_target;
            end else begin
              r_state   <= TRAP;
              r_trap    <= 1'b1;
              r_trap_pc <= redirect_target;
            end
          end else if (!stall) begin
            r_pc <= r_pc + 32'd4;
          end
        end
        default: begin
          if (start) begin
            r_state       <= RUN;
            r_pc          <= RESET_VECTOR;
            r_fetch_count <= 32'h0000_0000;
            r_trap        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural ownership/PC model checked every cycle,
// plus literal expectations along the directed scenario.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_data = 32'h0;
  logic        ld_ready;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic        fetch_valid;
  logic [31:0] fetch_count;
  logic        trap;
  logic [31:0] trap_pc;

  int checks = 0;
  int failures = 0;

  fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .pc(pc), .fetch_valid(fetch_valid), .fetch_count(fetch_count),
    .trap(trap), .trap_pc(trap_pc)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns memory (core running or loader), plus PC, count and trap record.
  logic        m_running = 1'b0;
  logic [31:0] m_pc = RV;
  logic [31:0] m_count = 32'h0;
  logic        m_trap = 1'b0;
  logic [31:0] m_trap_pc = 32'h0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_running <= 1'b0;
      m_pc      <= RV;
      m_count   <= 32'h0;
      m_trap    <= 1'b0;
      m_trap_pc <= 32'h0;
    end else if (m_running) begin
      if (halt) begin
        m_running <= 1'b0;
        m_count   <= m_count + (stall ? 32'd0 : 32'd1);
      end else if (start) begin
        m_pc    <= RV;
        m_count <= 32'h0;
      end else begin
        m_count <= m_count + (stall ? 32'd0 : 32'd1);
        if (redirect_valid && (redirect_target % 4 == 0)) begin
          m_pc <= redirect_target;
        end else if (redirect_valid) begin
          m_running <= 1'b0;
          m_trap    <= 1'b1;
          m_trap_pc <= redirect_target;
        end else if (!stall) begin
          m_pc <= m_pc + 32'd4;
        end
      end
    end else if (start) begin
      m_running <= 1'b1;
      m_pc      <= RV;
      m_count   <= 32'h0;
      m_trap    <= 1'b0;
    end
  end

  always @(negedge clock) begin
    logic aligned;
    aligned = (ld_addr % 4 == 0);
    check("pc", pc, m_pc);
    check("fetch_count", fetch_count, m_count);
    check("trap", {31'h0, trap}, {31'h0, m_trap});
    check("trap_pc", trap_pc, m_trap_pc);
    if (m_running) begin
      check("imem_addr", imem_addr, m_pc);
      check("imem_we", {31'h0, imem_we}, 32'h0);
      check("imem_wdata", imem_wdata, 32'h0);
      check("ld_ready", {31'h0, ld_ready}, 32'h0);
      check("fetch_valid", {31'h0, fetch_valid}, {31'h0, !stall});
    end else begin
      check("imem_addr", imem_addr, ld_addr);
      check("imem_we", {31'h0, imem_we}, {31'h0, (!reset && ld_valid && aligned)});
      check("imem_wdata", imem_wdata, ld_data);
      check("ld_ready", {31'h0, ld_ready}, {31'h0, (!reset && aligned)});
      check("fetch_valid", {31'h0, fetch_valid}, 32'h0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_trap", {31'h0, trap}, 32'h0);
    check("rst_trap_pc", trap_pc, 32'h0);
    check("rst_we", {31'h0, imem_we}, 32'h0);

    // Load two words, then start.
    reset = 1'b0; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h0050_0093;
    #1;
    check("load0_we", {31'h0, imem_we}, 32'h1);
    check("load0_wdata", imem_wdata, 32'h0050_0093);
    step();
    ld_addr = 32'h4; ld_data = 32'h0010_0113;
    step();
    ld_valid = 1'b0; start = 1'b1;
    #1;
    check("start_fv_low", {31'h0, fetch_valid}, 32'h0);
    step(); start = 1'b0;
    check("run_pc0", pc, 32'h0);
    check("run_fv_high", {31'h0, fetch_valid}, 32'h1);
    step(); check("run_pc4", pc, 32'h4);
    step(); check("run_pc8", pc, 32'h8);
    step(); check("run_pcC", pc, 32'hC);
    check("run_count3", fetch_count, 32'd3);

    // Redirect back to 0x8, then redirect+stall to 0x40, then stall two cycles.
    redirect_valid = 1'b1; redirect_target = 32'h8;
    step(); redirect_target = 32'h40; stall = 1'b1;
    check("redir_pc8", pc, 32'h8);
    check("redir_count4", fetch_count, 32'd4);
    step(); redirect_valid = 1'b0;
    check("redir_stall_pc40", pc, 32'h40);
    check("redir_stall_count", fetch_count, 32'd4);
    step(); check("stall1_pc", pc, 32'h40);
    step(); stall = 1'b0;
    check("stall2_pc", pc, 32'h40);
    check("stall2_count", fetch_count, 32'd4);
    step(); check("resume_pc44", pc, 32'h44);
    check("resume_count5", fetch_count, 32'd5);

    // Misaligned redirect -> TRAP.
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step(); redirect_valid = 1'b0;
    check("trap_flag", {31'h0, trap}, 32'h1);
    check("trap_pc_val", trap_pc, 32'h42);
    check("trap_fv", {31'h0, fetch_valid}, 32'h0);
    check("trap_ld_ready", {31'h0, ld_ready}, 32'h1);
    check("trap_pc_frozen", pc, 32'h44);
    check("trap_count6", fetch_count, 32'd6);
    start = 1'b1;
    step(); start = 1'b0;
    check("trap_cleared", {31'h0, trap}, 32'h0);
    check("restart_pc", pc, RV);
    check("restart_count", fetch_count, 32'h0);

    // Halt together with redirect at pc=0x10.
    redirect_valid = 1'b1; redirect_target = 32'h10;
    step(); halt = 1'b1; redirect_target = 32'h80;
    step(); halt = 1'b0; redirect_valid = 1'b0;
    check("halt_pc", pc, 32'h10);
    check("halt_fv", {31'h0, fetch_valid}, 32'h0);
    check("halt_count", fetch_count, 32'd2);
    ld_valid = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
    #1;
    check("halt_ld_we", {31'h0, imem_we}, 32'h1);
    check("halt_ld_addr", imem_addr, 32'h10);
    ld_addr = 32'h11;
    #1;
    check("misaligned_ready", {31'h0, ld_ready}, 32'h0);
    check("misaligned_we", {31'h0, imem_we}, 32'h0);
    step();

    // Start with a simultaneous loader write, then run across the 2^32 wrap.
    ld_addr = 32'h14; start = 1'b1;
    #1;
    check("start_write_we", {31'h0, imem_we}, 32'h1);
    step(); ld_valid = 1'b0; start = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF8;
    step(); redirect_valid = 1'b0;
    check("wrap_pcF8", pc, 32'hFFFF_FFF8);
    step(); check("wrap_pcFC", pc, 32'hFFFF_FFFC);
    step(); check("wrap_pc0", pc, 32'h0);
    step();

    // start beats redirect in RUN; halt with stall does not count.
    start = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
    step(); start = 1'b0; redirect_valid = 1'b0;
    check("start_over_redir_pc", pc, RV);
    check("start_over_redir_cnt", fetch_count, 32'h0);
    halt = 1'b1; stall = 1'b1;
    step(); halt = 1'b0; stall = 1'b0;
    check("halt_stall_count", fetch_count, 32'h0);

    // Reset mid-RUN.
    start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    check("pre_reset_pc", pc, 32'h8);
    reset = 1'b1;
    #1;
    check("midrun_rst_pc", pc, RV);
    check("midrun_rst_count", fetch_count, 32'h0);
    check("midrun_rst_fv", {31'h0, fetch_valid}, 32'h0);
    step(); reset = 1'b0;

    // Reset mid-load.
    ld_valid = 1'b1; ld_addr = 32'h20; ld_data = 32'h1234_5678;
    #1;
    check("preload_we", {31'h0, imem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("midload_rst_we", {31'h0, imem_we}, 32'h0);
    step(); reset = 1'b0; ld_valid = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
